// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: FSM state encoding, access-size helper
// and the default word geometry.
package lsu_pkg;

    localparam int LLEN_DEFAULT = 64;
    localparam int BYTES        = LLEN_DEFAULT / 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ1 = 3'd1,
        S_RSP1 = 3'd2,
        S_REQ2 = 3'd3,
        S_RSP2 = 3'd4,
        S_DONE = 3'd5
    } lsu_state_e;

    // Access size in bytes from funct3[1:0]: 1, 2, 4 or 8.
    function automatic logic [3:0] access_size(input logic [1:0] size_code);
        return 4'd1 << size_code;
    endfunction

endpackage

// File: rtl/load_merge_shifter.sv
// Funnel shift: returns the low LLEN bits of {hi,lo} >> 8*off.
// Shared with the store path, so it stays purely combinational.
module load_merge_shifter #(
    parameter int LLEN = 64
) (
    input  logic [2*LLEN-1:0]          din,
    input  logic [$clog2(LLEN/8)-1:0]  off,
    output logic [LLEN-1:0]            dout
);

    assign dout = LLEN'(din >> {off, 3'b000});

endmodule

// File: rtl/load_misalign_merge.sv
// Load misalignment handler: splits word-crossing loads into two aligned reads
// and merges the beats into one realigned word for the subword-read stage.
module load_misalign_merge
    import lsu_pkg::*;
#(
    parameter int LLEN    = BYTES * 8,
    parameter int PA_BITS = 56
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               LoadReqValid,
    output logic               LoadReqReady,
    input  logic [PA_BITS-1:0] ReqPAdr,
    input  logic [2:0]         ReqFunct3,
    input  logic               ReqBigEndian,
    input  logic               MisalignEn,
    output logic               MemReqValid,
    output logic [PA_BITS-1:0] MemReqAdr,
    input  logic               MemReqReady,
    input  logic               MemRspValid,
    input  logic [LLEN-1:0]    MemRspData,
    output logic [LLEN-1:0]    ReadDataWordMux,
    output logic [2:0]         PAdrLow,
    output logic [2:0]         Funct3Out,
    output logic               RspValid,
    output logic               LoadMisalignedFault
);

    localparam int B    = LLEN / 8;
    localparam int OFFW = $clog2(B);

    lsu_state_e         state_q, state_d;
    logic [PA_BITS-1:0] base_q;
    logic [OFFW-1:0]    off_q;
    logic               mis_q, cross_q;
    logic [2:0]         funct3_q;
    logic [2:0]         padr_pend_q, padr_low_q;
    logic [LLEN-1:0]    lo_q, rdata_q;
    logic               fault_q;

    // Request decode, only meaningful while idle.
    logic [OFFW-1:0] off_w;
    logic [3:0]      size_w;
    logic [4:0]      end_w;
    logic            mis_w, cross_w, accept_w, fault_w, start_w;
    logic [2:0]      padr_sel_w;

    assign off_w      = ReqPAdr[OFFW-1:0];
    assign size_w     = access_size(ReqFunct3[1:0]);
    assign mis_w      = (({1'b0, ReqPAdr[2:0]} & (size_w - 4'd1)) != 4'd0);
    assign end_w      = 5'(off_w) + {1'b0, size_w};
    assign cross_w    = (end_w > 5'(B));
    assign accept_w   = (state_q == S_IDLE) && LoadReqValid;
    assign fault_w    = accept_w && mis_w && (!MisalignEn || ReqBigEndian);
    assign start_w    = accept_w && !fault_w;
    assign padr_sel_w = mis_w ? 3'b000 : {(LLEN == 64) && ReqPAdr[2], ReqPAdr[1:0]};

    // Non-crossing beats are shifted with zeros above; crossing uses {hi,lo}.
    logic [2*LLEN-1:0] shift_in_w;
    logic [LLEN-1:0]   merged_w, result_w;
    logic              final_w;

    assign shift_in_w = (state_q == S_RSP2) ? {MemRspData, lo_q} : {{LLEN{1'b0}}, MemRspData};
    assign final_w    = MemRspValid &&
                        (((state_q == S_RSP1) && !cross_q) || (state_q == S_RSP2));
    assign result_w   = mis_q ? merged_w : ((state_q == S_RSP2) ? lo_q : MemRspData);

    load_merge_shifter #(.LLEN(LLEN)) u_shifter (
        .din  (shift_in_w),
        .off  (off_q),
        .dout (merged_w)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_w)     state_d = S_REQ1;
            S_REQ1: if (MemReqReady) state_d = S_RSP1;
            S_RSP1: if (MemRspValid) state_d = cross_q ? S_REQ2 : S_DONE;
            S_REQ2: if (MemReqReady) state_d = S_RSP2;
            S_RSP2: if (MemRspValid) state_d = S_DONE;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        LoadReqReady = (state_q == S_IDLE);
        MemReqValid  = (state_q == S_REQ1) || (state_q == S_REQ2);
        RspValid     = (state_q == S_DONE);
        MemReqAdr    = '0;
        if (state_q == S_REQ1) MemReqAdr = base_q;
        if (state_q == S_REQ2) MemReqAdr = base_q + PA_BITS'(B);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q      <= '0;
            off_q       <= '0;
            mis_q       <= 1'b0;
            cross_q     <= 1'b0;
            funct3_q    <= 3'b000;
            padr_pend_q <= 3'b000;
            padr_low_q  <= 3'b000;
            lo_q        <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            fault_q <= fault_w;
            if (start_w) begin
                base_q      <= {ReqPAdr[PA_BITS-1:OFFW], {OFFW{1'b0}}};
                off_q       <= off_w;
                mis_q       <= mis_w;
                cross_q     <= cross_w;
                funct3_q    <= ReqFunct3;
                padr_pend_q <= padr_sel_w;
            end
            if ((state_q == S_RSP1) && MemRspValid) lo_q <= MemRspData;
            if (final_w) begin
                rdata_q    <= result_w;
                padr_low_q <= padr_pend_q;
            end
        end
    end

    assign ReadDataWordMux     = rdata_q;
    assign PAdrLow             = padr_low_q;
    assign Funct3Out           = funct3_q;
    assign LoadMisalignedFault = fault_q;

endmodule

// File: tb/tb_load_misalign_merge.sv
// Directed scoreboard bench for load_misalign_merge (LLEN=64, PA_BITS=56).
module tb_load_misalign_merge;

    localparam int LLEN = 64;
    localparam int PA   = 56;

    logic            clk = 1'b0;
    logic            reset;
    logic            LoadReqValid, LoadReqReady;
    logic [PA-1:0]   ReqPAdr;
    logic [2:0]      ReqFunct3;
    logic            ReqBigEndian, MisalignEn;
    logic            MemReqValid;
    logic [PA-1:0]   MemReqAdr;
    logic            MemReqReady, MemRspValid;
    logic [LLEN-1:0] MemRspData;
    logic [LLEN-1:0] ReadDataWordMux;
    logic [2:0]      PAdrLow, Funct3Out;
    logic            RspValid, LoadMisalignedFault;

    load_misalign_merge #(.LLEN(LLEN), .PA_BITS(PA)) dut (
        .clk                 (clk),
        .reset               (reset),
        .LoadReqValid        (LoadReqValid),
        .LoadReqReady        (LoadReqReady),
        .ReqPAdr             (ReqPAdr),
        .ReqFunct3           (ReqFunct3),
        .ReqBigEndian        (ReqBigEndian),
        .MisalignEn          (MisalignEn),
        .MemReqValid         (MemReqValid),
        .MemReqAdr           (MemReqAdr),
        .MemReqReady         (MemReqReady),
        .MemRspValid         (MemRspValid),
        .MemRspData          (MemRspData),
        .ReadDataWordMux     (ReadDataWordMux),
        .PAdrLow             (PAdrLow),
        .Funct3Out           (Funct3Out),
        .RspValid            (RspValid),
        .LoadMisalignedFault (LoadMisalignedFault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [2:0]  padr;
        logic [2:0]  f3;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Scoreboard: every RspValid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (RspValid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: RspValid=1 data=%h, required no response", ReadDataWordMux);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({ReadDataWordMux, PAdrLow, Funct3Out} !== {e.data, e.padr, e.f3}) begin
                    n_fail++;
                    $display("FAIL rsp_data: got data=%h padr=%0d f3=%b, required data=%h padr=%0d f3=%b",
                             ReadDataWordMux, PAdrLow, Funct3Out, e.data, e.padr, e.f3);
                end else begin
                    $display("rsp data=%h padr=%0d f3=%b ok", ReadDataWordMux, PAdrLow, Funct3Out);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        LoadReqValid = 1'b0;
        ReqPAdr      = '0;
        ReqFunct3    = 3'b000;
        ReqBigEndian = 1'b0;
        MisalignEn   = 1'b0;
        MemReqReady  = 1'b0;
        MemRspValid  = 1'b0;
        MemRspData   = '0;
        step();
        step();
        n_checks++;
        if ({LoadReqReady, MemReqValid, RspValid, LoadMisalignedFault} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/memv/rspv/fault=%b required 1000",
                     {LoadReqReady, MemReqValid, RspValid, LoadMisalignedFault});
        end
        n_checks++;
        if ({MemReqAdr, ReadDataWordMux, PAdrLow, Funct3Out} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: adr=%h data=%h padr=%0d f3=%b required all 0",
                     MemReqAdr, ReadDataWordMux, PAdrLow, Funct3Out);
        end
        reset = 1'b0;
        $display("reset checked");
    endtask

    // One complete load with single-cycle memory handshakes except an optional
    // REQ2 stall (with a stray response injected during the stall).
    task automatic do_load(input string name, input logic [PA-1:0] adr, input logic [2:0] f3,
                           input logic [63:0] beat0, input logic [63:0] beat1, input bit two,
                           input logic [PA-1:0] a0, input logic [PA-1:0] a1,
                           input logic [63:0] exp_data, input logic [2:0] exp_padr, input int stall);
        exp_t e;
        n_checks++;
        if (LoadReqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready: LoadReqReady=%b required 1", name, LoadReqReady);
        end
        LoadReqValid = 1'b1;
        ReqPAdr      = adr;
        ReqFunct3    = f3;
        MisalignEn   = 1'b1;
        ReqBigEndian = 1'b0;
        e.data = exp_data; e.padr = exp_padr; e.f3 = f3;
        exp_q.push_back(e);
        step();
        LoadReqValid = 1'b0;
        ReqPAdr      = PA'({$urandom, $urandom});
        ReqFunct3    = 3'($urandom);
        n_checks++;
        if (MemReqValid !== 1'b1 || MemReqAdr !== a0) begin
            n_fail++;
            $display("FAIL %s_req1: valid=%b adr=%h required 1 %h", name, MemReqValid, MemReqAdr, a0);
        end
        MemReqReady = 1'b1;
        step();
        MemReqReady = 1'b0;
        MemRspValid = 1'b1;
        MemRspData  = beat0;
        step();
        MemRspValid = 1'b0;
        MemRspData  = {$urandom, $urandom};
        if (two) begin
            for (int s = 0; s <= stall; s++) begin
                n_checks++;
                if (MemReqValid !== 1'b1 || MemReqAdr !== a1) begin
                    n_fail++;
                    $display("FAIL %s_req2_c%0d: valid=%b adr=%h required 1 %h",
                             name, s, MemReqValid, MemReqAdr, a1);
                end
                if (s < stall) begin
                    MemRspValid = (s == 1);
                    step();
                    MemRspValid = 1'b0;
                end
            end
            MemReqReady = 1'b1;
            step();
            MemReqReady = 1'b0;
            MemRspValid = 1'b1;
            MemRspData  = beat1;
            step();
            MemRspValid = 1'b0;
            MemRspData  = {$urandom, $urandom};
        end
        n_checks++;
        if (RspValid !== 1'b1 || LoadReqReady !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_latency: RspValid=%b ready=%b required 1 0", name, RspValid, LoadReqReady);
        end
        step();
        n_checks++;
        if (RspValid !== 1'b0 || LoadReqReady !== 1'b1 || ReadDataWordMux !== exp_data) begin
            n_fail++;
            $display("FAIL %s_hold: RspValid=%b ready=%b data=%h required 0 1 %h",
                     name, RspValid, LoadReqReady, ReadDataWordMux, exp_data);
        end
        $display("load %s adr=%h done", name, adr);
    endtask

    task automatic test_fault(input string name, input logic [PA-1:0] adr, input logic [2:0] f3,
                              input logic misen, input logic be);
        LoadReqValid = 1'b1;
        ReqPAdr      = adr;
        ReqFunct3    = f3;
        MisalignEn   = misen;
        ReqBigEndian = be;
        step();
        LoadReqValid = 1'b0;
        ReqBigEndian = 1'b0;
        n_checks++;
        if ({LoadMisalignedFault, MemReqValid, LoadReqReady} !== 3'b101) begin
            n_fail++;
            $display("FAIL %s_pulse: fault/memv/ready=%b required 101", name,
                     {LoadMisalignedFault, MemReqValid, LoadReqReady});
        end
        step();
        n_checks++;
        if ({LoadMisalignedFault, MemReqValid, LoadReqReady} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s_after: fault/memv/ready=%b required 001", name,
                     {LoadMisalignedFault, MemReqValid, LoadReqReady});
        end
        $display("fault %s adr=%h done", name, adr);
    endtask

    task automatic test_reset_midop();
        LoadReqValid = 1'b1;
        ReqPAdr      = 56'h5006;
        ReqFunct3    = 3'b010;
        MisalignEn   = 1'b1;
        step();
        LoadReqValid = 1'b0;
        MemReqReady  = 1'b1;
        step();
        MemReqReady  = 1'b0;
        MemRspValid  = 1'b1;
        MemRspData   = 64'h1111111111111111;
        step();
        MemRspValid  = 1'b0;
        MemReqReady  = 1'b1;
        step();
        MemReqReady  = 1'b0;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
        n_checks++;
        if ({LoadReqReady, MemReqValid, RspValid} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_idle: ready/memv/rspv=%b required 100",
                     {LoadReqReady, MemReqValid, RspValid});
        end
        MemRspValid = 1'b1;
        MemRspData  = 64'h2222222222222222;
        step();
        MemRspValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (RspValid !== 1'b0 || MemReqValid !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_late_rsp_c%0d: RspValid=%b memv=%b required 0 0",
                         i, RspValid, MemReqValid);
            end
            step();
        end
        $display("reset in RSP2 done");
    endtask

    initial begin
        test_reset();
        do_load("aligned_lw", 56'h1004, 3'b010, 64'h89ABCDEF01234567, 64'h0, 1'b0,
                56'h1000, 56'h0, 64'h89ABCDEF01234567, 3'd4, 0);
        do_load("cross_lw", 56'h1006, 3'b010, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 1'b1,
                56'h1000, 56'h1008, 64'hBBCCDDEEFF001122, 3'd0, 0);
        do_load("mis_lh", 56'h1001, 3'b001, 64'h0000000000A1B2C3, 64'h0, 1'b0,
                56'h1000, 56'h0, 64'h000000000000A1B2, 3'd0, 0);
        do_load("aligned_ld", 56'h4000, 3'b011, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0,
                56'h4000, 56'h0, 64'hDEADBEEFCAFEF00D, 3'd0, 0);
        test_fault("mis_ld_noen", 56'h2003, 3'b011, 1'b0, 1'b0);
        test_fault("mis_lh_be", 56'h1001, 3'b001, 1'b1, 1'b1);
        do_load("stall_lwu", 56'h3007, 3'b110, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 1'b1,
                56'h3000, 56'h3008, 64'h0E0D0C0B0A090807, 3'd0, 4);
        test_reset_midop();
        do_load("wrap_lw", 56'hFFFFFFFFFFFFFE, 3'b010, 64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7, 1'b1,
                56'hFFFFFFFFFFFFF8, 56'h0, 64'hB2B3B4B5B6B7A0A1, 3'd0, 0);
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
